// File: rtl/jk_bank_driver.sv
// jk_bank_driver: write-side controller for a bank of WIDTH JK latches.
// A target word is accepted over a valid/ready handshake. Per-bit J/K
// excitation is derived from the target and the sampled latch outputs. The
// enable is pulsed and the bank is given SETTLE_CYCLES to settle. The outputs
// are then read back, and a failed write is retried up to MAX_RETRY times.
// All outputs are registered (Moore).
// Optional feature macro: JKDRV_ERRMASK_EN adds err_mask, which holds the
// mismatching bits captured on the edge that raises err.
//
// Handshake: a request transfers on any rising edge where req_valid &&
// req_ready. req_ready is high only while the FSM is IDLE, which includes the
// done/err pulse cycle. req_valid is ignored while busy.
module jk_bank_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             en_out,
  output logic             done,
  output logic             err,
`ifdef JKDRV_ERRMASK_EN
  output logic [WIDTH-1:0] err_mask,
`endif
  output logic             busy
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  target, target_n;
  logic [RW-1:0]     retry_cnt, retry_n;
  logic [SW-1:0]     settle_cnt, settle_n;
  logic [WIDTH-1:0]  j_n, k_n;
  logic              en_n, done_n, err_n, busy_n, ready_n;
`ifdef JKDRV_ERRMASK_EN
  logic [WIDTH-1:0]  mask_n;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_n  = state;
    target_n = target;
    retry_n  = retry_cnt;
    settle_n = settle_cnt;
    j_n      = '0;
    k_n      = '0;
    en_n     = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
`ifdef JKDRV_ERRMASK_EN
    mask_n   = err_mask;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_n = req_data;
          retry_n  = '0;
`ifdef JKDRV_ERRMASK_EN
          mask_n   = '0;
`endif
          if (q_in == req_data) begin
            // Bank already holds the target: complete without driving.
            done_n = 1'b1;
          end else begin
            state_n = DRIVE;
            en_n    = 1'b1;
            // Set-only / clear-only excitation; J=K=1 can never occur.
            j_n     = req_data & ~q_in;
            k_n     = ~req_data & q_in;
          end
        end
      end
      DRIVE: begin
        state_n  = SETTLE;
        settle_n = '0;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = CHECK;
        else                           settle_n = settle_cnt + 1'b1;
      end
      CHECK: begin
        if (q_in == target) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (retry_cnt < RETRY_MAX) begin
          retry_n = retry_cnt + 1'b1;
          state_n = DRIVE;
          en_n    = 1'b1;
          j_n     = target & ~q_in;
          k_n     = ~target & q_in;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
`ifdef JKDRV_ERRMASK_EN
          mask_n  = q_in ^ target;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      retry_cnt  <= '0;
      settle_cnt <= '0;
      j_out      <= '0;
      k_out      <= '0;
      en_out     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b0;
`ifdef JKDRV_ERRMASK_EN
      err_mask   <= '0;
`endif
    end else begin
      state      <= state_n;
      target     <= target_n;
      retry_cnt  <= retry_n;
      settle_cnt <= settle_n;
      j_out      <= j_n;
      k_out      <= k_n;
      en_out     <= en_n;
      done       <= done_n;
      err        <= err_n;
      busy       <= busy_n;
      req_ready  <= ready_n;
`ifdef JKDRV_ERRMASK_EN
      err_mask   <= mask_n;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Testbench for jk_bank_driver (WIDTH=4, SETTLE_CYCLES=2, MAX_RETRY=3).
// A behavioural JK latch bank with optional stuck-at bits drives q_in.
// Expected results come from a transaction-level model: each attempt leaves
// the bank at the target, with the stuck bits forced.
module tb_jk_bank_driver;

  localparam int W   = 4;
  localparam int S   = 2;
  localparam int MR  = 3;
  localparam int ATT = 2 + S;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] q_in;
  logic [W-1:0] j_out, k_out;
  logic         en_out, done, err, busy;
`ifdef JKDRV_ERRMASK_EN
  logic [W-1:0] err_mask;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Latch bank model controls.
  logic [W-1:0] bank_q     = '0;
  logic         preset_en  = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic [W-1:0] stuck0     = '0;
  logic [W-1:0] stuck1     = '0;

  jk_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .q_in      (q_in),
    .j_out     (j_out),
    .k_out     (k_out),
    .en_out    (en_out),
    .done      (done),
    .err       (err),
`ifdef JKDRV_ERRMASK_EN
    .err_mask  (err_mask),
`endif
    .busy      (busy)
  );

  // Clock.
  always #5 clk = ~clk;

  // JK latch bank: applies excitation while enabled, or loads a preset.
  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else if (en_out) begin
      for (int b = 0; b < W; b++) begin
        case ({j_out[b], k_out[b]})
          2'b10:   bank_q[b] <= 1'b1;
          2'b01:   bank_q[b] <= 1'b0;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  assign q_in = (bank_q & ~stuck0) | stuck1;

  function automatic logic [W-1:0] apply_stuck(input logic [W-1:0] v,
                                               input logic [W-1:0] s0,
                                               input logic [W-1:0] s1);
    return (v & ~s0) | s1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One request from bank value q0 to target t with the given stuck bits.
  task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] t,
                         input logic [W-1:0] s0, input logic [W-1:0] s1);
    logic [W-1:0] start, after, exp_j, exp_k;
    int exp_cyc, exp_pulses, cyc, pulses, bad_pos, overlap, bad_busy;
    bit exp_err, got_end, first_en_seen;
    logic [W-1:0] first_j, first_k;
    // Reference expectations.
    start = apply_stuck(q0, s0, s1);
    after = apply_stuck(t, s0, s1);
    exp_j = t & ~start;
    exp_k = ~t & start;
    exp_err = 1'b0;
    if (start == t) begin
      exp_cyc = 1; exp_pulses = 0;
    end else if (after == t) begin
      exp_cyc = ATT + 1; exp_pulses = 1;
    end else begin
      exp_cyc = (MR + 1) * ATT + 1; exp_pulses = MR + 1; exp_err = 1'b1;
    end
    // Preset the bank.
    @(negedge clk);
    preset_val = q0; preset_en = 1'b1; stuck0 = s0; stuck1 = s1;
    @(posedge clk); #1 preset_en = 1'b0;
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = t;
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = W'($urandom_range(0, 15));
    cyc = 0; pulses = 0; bad_pos = 0; overlap = 0; bad_busy = 0;
    got_end = 1'b0; first_en_seen = 1'b0; first_j = '0; first_k = '0;
    while (!got_end && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if ((j_out & k_out) != '0) overlap++;
      if (en_out) begin
        pulses++;
        if (((cyc - 1) % ATT) != 0) bad_pos++;
        if (!first_en_seen) begin
          first_en_seen = 1'b1; first_j = j_out; first_k = k_out;
        end
      end else if ((j_out | k_out) != '0) bad_pos++;
`ifdef JKDRV_ERRMASK_EN
      if (cyc == 1) chk("errmask_cleared", 32'(err_mask), 32'd0);
`endif
      if (done || err) begin
        got_end = 1'b1;
        chk("end_cycle", 32'(cyc), 32'(exp_cyc));
        chk("done", 32'(done), 32'(!exp_err));
        chk("err", 32'(err), 32'(exp_err));
        chk("ready_in_end_cycle", 32'(req_ready), 32'd1);
        chk("busy_in_end_cycle", 32'(busy), 32'd0);
`ifdef JKDRV_ERRMASK_EN
        if (exp_err) chk("err_mask", 32'(err_mask), 32'(after ^ t));
`endif
      end else begin
        if (!busy) bad_busy++;
        // A request offered while busy must be ignored.
        req_valid = (cyc == 2);
        req_data  = W'($urandom_range(0, 15));
      end
    end
    req_valid = 1'b0;
    chk("completed", 32'(got_end), 32'd1);
    chk("en_pulses", 32'(pulses), 32'(exp_pulses));
    chk("en_position", 32'(bad_pos), 32'd0);
    chk("jk_overlap", 32'(overlap), 32'd0);
    chk("busy_during_op", 32'(bad_busy), 32'd0);
    if (exp_pulses > 0) begin
      chk("first_j", 32'(first_j), 32'(exp_j));
      chk("first_k", 32'(first_k), 32'(exp_k));
    end
    chk("final_q", 32'(q_in), 32'(exp_pulses > 0 ? after : start));
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({j_out, k_out, en_out, done, err, busy, req_ready}), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    chk("rst_release_busy", 32'(busy), 32'd0);

    // Directed cases.
    run_txn(4'b0000, 4'b1010, 4'b0000, 4'b0000);   // set bits
    run_txn(4'b1010, 4'b0110, 4'b0000, 4'b0000);   // mixed set/clear
    run_txn(4'b0101, 4'b0101, 4'b0000, 4'b0000);   // fast path
    run_txn(4'b0000, 4'b0001, 4'b0001, 4'b0000);   // bit0 stuck at 0
    run_txn(4'b1111, 4'b0000, 4'b0000, 4'b0000);   // clear all

    // Abort in the first SETTLE cycle.
    @(negedge clk);
    preset_val = 4'b0000; preset_en = 1'b1; stuck0 = '0; stuck1 = '0;
    @(posedge clk); #1 preset_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_data = 4'b1010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);                 // cycle 1 (DRIVE)
    @(negedge clk);                 // cycle 2 (SETTLE)
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({j_out, k_out, en_out, busy, done, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_pulse", 32'({done, err}), 32'd0);
    run_txn(4'b1010, 4'b0110, 4'b0000, 4'b0000);

    // Randomized requests, some with a stuck bit.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] q0, t, s0, s1, m;
      q0 = W'($urandom_range(0, 15));
      t  = W'($urandom_range(0, 15));
      s0 = '0; s1 = '0;
      if ($urandom_range(0, 2) == 0) begin
        m = W'(1 << $urandom_range(0, W - 1));
        if ($urandom_range(0, 1) == 0) s0 = m; else s1 = m;
      end
      run_txn(q0, t, s0, s1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
